// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : MIPS ALU operand decode feeding a 2-entry skid FIFO to the ALU.
// Revision : 1.0
// ============================================================================
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  func,
  output logic        illegal
);

  localparam logic [3:0] c_FN_AND  = 4'b0000;
  localparam logic [3:0] c_FN_OR   = 4'b0001;
  localparam logic [3:0] c_FN_XOR  = 4'b0010;
  localparam logic [3:0] c_FN_ADD  = 4'b0100;
  localparam logic [3:0] c_FN_SLTU = 4'b0110;
  localparam logic [3:0] c_FN_SUB  = 4'b1100;
  localparam logic [3:0] c_FN_SLT  = 4'b1101;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic [3:0]  w_func;
  logic        w_ill;
  logic [68:0] w_entry;
  logic        w_push;
  logic        w_pop;
  logic        w_unused;

  logic [68:0] r_mem [0:1];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  assign w_op     = instr[31:26];
  assign w_fn     = instr[5:0];
  assign w_imm    = instr[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'h0000, w_imm};
  // Register-number fields are resolved upstream; only opcode/funct/imm matter here.
  assign w_unused = ^{instr[25:16], instr[10:6]};

  always_comb begin
    w_in1  = rs_data;
    w_in2  = rt_data;
    w_func = c_FN_AND;
    w_ill  = 1'b1;
    case (w_op)
      6'h00: begin
        w_ill = 1'b0;
        case (w_fn)
          6'h20, 6'h21: w_func = c_FN_ADD;
          6'h22, 6'h23: w_func = c_FN_SUB;
          6'h24:        w_func = c_FN_AND;
          6'h25:        w_func = c_FN_OR;
          6'h26:        w_func = c_FN_XOR;
          6'h2A:        w_func = c_FN_SLT;
          6'h2B:        w_func = c_FN_SLTU;
          default:      w_ill  = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin w_in2 = w_sext; w_func = c_FN_ADD;  w_ill = 1'b0; end
      6'h0A:        begin w_in2 = w_sext; w_func = c_FN_SLT;  w_ill = 1'b0; end
      6'h0B:        begin w_in2 = w_sext; w_func = c_FN_SLTU; w_ill = 1'b0; end
      6'h0C:        begin w_in2 = w_zext; w_func = c_FN_AND;  w_ill = 1'b0; end
      6'h0D:        begin w_in2 = w_zext; w_func = c_FN_OR;   w_ill = 1'b0; end
      6'h0E:        begin w_in2 = w_zext; w_func = c_FN_XOR;  w_ill = 1'b0; end
      6'h0F: begin
        w_in1  = {w_imm, 16'h0000};
        w_in2  = 32'h0000_0000;
        w_func = c_FN_OR;
        w_ill  = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_entry   = {w_ill, w_func, w_in1, w_in2};
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Storage is cleared on reset so the output fields read as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign {illegal, func, in1, in2} = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Directed + randomized checks of alu_issue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  func;
  logic        illegal;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_issue u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in1       (in1),
    .in2       (in2),
    .func      (func),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    ent_t        e;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = 32'($signed(ins[15:0]));
    zx = 32'(ins[15:0]);
    e  = '{a: rs, b: rt, f: 4'b0000, ill: 1'b1};
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h21: e = '{a: rs, b: rt, f: 4'b0100, ill: 1'b0};
          6'h22, 6'h23: e = '{a: rs, b: rt, f: 4'b1100, ill: 1'b0};
          6'h24:        e = '{a: rs, b: rt, f: 4'b0000, ill: 1'b0};
          6'h25:        e = '{a: rs, b: rt, f: 4'b0001, ill: 1'b0};
          6'h26:        e = '{a: rs, b: rt, f: 4'b0010, ill: 1'b0};
          6'h2A:        e = '{a: rs, b: rt, f: 4'b1101, ill: 1'b0};
          6'h2B:        e = '{a: rs, b: rt, f: 4'b0110, ill: 1'b0};
          default: ;
        endcase
      end
      6'h08, 6'h09: e = '{a: rs, b: sx, f: 4'b0100, ill: 1'b0};
      6'h0A:        e = '{a: rs, b: sx, f: 4'b1101, ill: 1'b0};
      6'h0B:        e = '{a: rs, b: sx, f: 4'b0110, ill: 1'b0};
      6'h0C:        e = '{a: rs, b: zx, f: 4'b0000, ill: 1'b0};
      6'h0D:        e = '{a: rs, b: zx, f: 4'b0001, ill: 1'b0};
      6'h0E:        e = '{a: rs, b: zx, f: 4'b0010, ill: 1'b0};
      6'h0F:        e = '{a: {ins[15:0], 16'h0000}, b: 32'h0, f: 4'b0001, ill: 1'b0};
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("in1",     in1,           q[0].a);
      chk("in2",     in2,           q[0].b);
      chk("func",    32'(func),     32'(q[0].f));
      chk("illegal", 32'(illegal),  32'(q[0].ill));
    end
  endtask

  // Call at 1 time unit after a rising edge; returns at the same phase.
  task automatic step();
    bit   acc;
    bit   drn;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    drn = out_ready && (q.size() > 0);
    e   = ref_dec(instr, rs_data, rt_data);
    @(posedge clk);
    #1;
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(e);
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_in1",       in1,            32'd0);
    chk("rst_in2",       in2,            32'd0);
    chk("rst_func",      32'(func),      32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    q.delete();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    instr    = ins;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  ops [13];
    logic [5:0]  fns [10];
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h23};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h27};
    ins = $urandom;
    ins[31:26] = ops[$urandom_range(0, 12)];
    if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = fns[$urandom_range(0, 9)];
    return ins;
  endfunction

  logic [31:0] hold_in1;

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'h0;
    rs_data   = 32'h0;
    rt_data   = 32'h0;
    #1;
    do_reset();

    // addu $3,$1,$2 appears the cycle after acceptance
    out_ready = 1'b1;
    drive(32'h0022_1821, 32'd78375, 32'd42596);
    step();
    chk("addu_valid", 32'(out_valid), 32'd1);
    chk("addu_in1",   in1,            32'd78375);
    chk("addu_in2",   in2,            32'd42596);
    chk("addu_func",  32'(func),      32'b0100);

    drive({6'h0A, 5'd1, 5'd2, 16'hFFFF}, 32'h0000_000F, 32'h1234_5678);
    step();
    chk("slti_in2",  in2,       32'hFFFF_FFFF);
    chk("slti_func", 32'(func), 32'b1101);

    drive({6'h0D, 5'd1, 5'd2, 16'hFF00}, 32'hA5A5_A5A5, 32'h0);
    step();
    chk("ori_in2",  in2,       32'h0000_FF00);
    chk("ori_func", 32'(func), 32'b0001);

    drive({6'h0F, 5'd0, 5'd4, 16'hFFFF}, 32'h5555_5555, 32'h6666_6666);
    step();
    chk("lui_in1",  in1,       32'hFFFF_0000);
    chk("lui_in2",  in2,       32'h0);
    chk("lui_func", 32'(func), 32'b0001);

    drive({6'h3F, 26'h155_5555}, 32'h1111_1111, 32'h2222_2222);
    step();
    chk("bad_illegal", 32'(illegal), 32'd1);
    chk("bad_func",    32'(func),    32'd0);
    chk("bad_in1",     in1,          32'h1111_1111);
    in_valid = 1'b0;
    step();

    // Stalled consumer: only two of three pushes land, head holds steady
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_0020, 32'(100 + i), 32'(200 + i));
      step();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    hold_in1 = in1;
    in_valid = 1'b0;
    step();
    step();
    chk("stall_hold", in1, hold_in1);
    chk("stall_head", in1, 32'd100);
    out_ready = 1'b1;
    step();
    chk("drain_second", in1, 32'd101);
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Occupancy 1 with simultaneous accept and drain
    drive(32'h0000_0024, 32'd7, 32'd8);
    step();
    drive(32'h0000_0025, 32'd9, 32'd10);
    step();
    chk("pass_in_ready", 32'(in_ready), 32'd1);
    chk("pass_in1",      in1,           32'd9);
    in_valid = 1'b0;
    step();

    // Reset with two entries buffered
    out_ready = 1'b0;
    drive(32'h0000_0026, 32'd1, 32'd2);
    step();
    step();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    do_reset();
    step();
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    drive(32'h0000_002A, 32'd33, 32'd44);
    step();
    chk("post_rst_in1", in1, 32'd33);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = rand_instr();
      rs_data   = $urandom;
      rt_data   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
